grey2bin_decoder: RTL
=====================

GREY2BIN_DECODER -- requirements
Module: grey2bin_decoder

Interface
REQ-001 Parameter WIDTH, default 4: code width in bits; legal range 2..16.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  gray_in holds a code word to decode.
REQ-005 in_ready  output  1  block accepts a word (1 only in IDLE).
REQ-006 gray_in  input  WIDTH  Gray code word, MSB at index WIDTH-1.
REQ-007 out_valid  output  1  bin_out and step flags are valid.
REQ-008 out_ready  input  1  consumer accepts the result.
REQ-009 bin_out  output  WIDTH  decoded binary value.
REQ-010 step_err  output  1  the result is not a +/-1 step from the previous accepted result.
REQ-011 step_dir  output  1  1 = +1 step, 0 = -1 step or no step.
REQ-012 hist_clr  input  1  synchronous clear of result history.
REQ-013 err_cnt  output  8  saturating count of results delivered with step_err=1.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, CONV and DONE.
REQ-015 IDLE: in_ready=1; on the edge where in_valid=1, latch gray_in, set the bit index to WIDTH-1 and go to CONV.
REQ-016 CONV: resolve one bit per clock, MSB first, using bin[WIDTH-1]=g[WIDTH-1] and bin[i]=bin[i+1]^g[i]; in_ready=0.
REQ-017 CONV SHALL last exactly WIDTH clocks; on the edge that resolves bit 0, go to DONE.
REQ-018 Latency: out_valid SHALL be high in the cycle after the WIDTH-th edge following the accept edge (4 edges for WIDTH=4).
REQ-019 DONE: out_valid=1, in_ready=0; bin_out, step_err and step_dir SHALL stay stable until the edge where out_ready=1.
REQ-020 On that edge: return to IDLE, load history with bin_out, set hist_valid=1, and increment err_cnt if step_err=1.
REQ-021 Back-to-back words: a new word can be accepted no earlier than the cycle after the output handshake; in_valid SHALL be ignored outside IDLE.
REQ-022 Step check, evaluated on entry to DONE with diff = (bin - history) mod 2^WIDTH:
- hist_valid=0: step_err=0, step_dir=0.
- diff=1: step_err=0, step_dir=1.
- diff=2^WIDTH-1: step_err=0, step_dir=0.
- any other diff, including 0: step_err=1, step_dir=0.
REQ-023 Wrap-around (all-ones to 0, and 0 to all-ones) SHALL count as a legal +/-1 step.
REQ-024 hist_clr=1 SHALL clear hist_valid on the same edge; if it coincides with an output handshake, the clear wins and hist_valid=0.
REQ-025 hist_clr SHALL NOT change the step flags of a result already in DONE.
REQ-026 err_cnt SHALL saturate at 255.
REQ-027 err_cnt SHALL NOT be cleared by hist_clr.

Reset
REQ-028 While rst_n=0, asynchronously: state=IDLE, in_ready=1, out_valid=0, bin_out=0, step_err=0, step_dir=0, err_cnt=0, hist_valid=0, history=0, internal shift and index registers=0.
REQ-029 Reset asserted during CONV or DONE SHALL abort the word; no out_valid pulse for that word ever occurs.
REQ-030 The first result after reset SHALL report step_err=0.

Verification (WIDTH=4)
REQ-031 After reset, send gray 1101 with out_ready=1 -> bin_out=1001 with out_valid high 4 edges after accept; step_err=0; err_cnt=0.
REQ-032 Send gray 0000, 0001, 0011, 0010 back-to-back -> bin 0,1,2,3; second to fourth results have step_err=0, step_dir=1.
REQ-033 Send gray 1000, 0000, 1000 -> bin 15, 0, 15; step_err=0 throughout; step_dir 1 then 0.
REQ-034 Send gray 0001 then 0110, hold out_ready=0 for 5 cycles -> bin_out=0100, step_err=1, flags stable, in_ready=0, extra in_valid ignored; after release err_cnt=1.
REQ-035 Pulse rst_n low 2 clocks after accept -> out_valid never rises; the next word returns step_err=0.
REQ-036 Force 256 consecutive step errors -> err_cnt holds at 255; hist_clr together with a handshake -> next result has step_err=0.

Source files
------------

// File: rtl/grey2bin_decoder.sv
// Serial Gray-to-binary decoder: one bit per clock, MSB first, with a step check
// against the previously delivered result and a saturating step-error counter.
module grey2bin_decoder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] gray_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] bin_out,
  output logic             step_err,
  output logic             step_dir,
  input  logic             hist_clr,
  output logic [7:0]       err_cnt
);

  localparam int IDXW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic [WIDTH-1:0]  gray_r;
  logic [WIDTH-1:0]  shift_r;
  logic [WIDTH-1:0]  bin_r;
  logic [WIDTH-1:0]  hist_r;
  logic [IDXW-1:0]   idx_r;
  logic              hist_valid_r;
  logic              in_ready_r;
  logic              out_valid_r;
  logic              step_err_r;
  logic              step_dir_r;
  logic [7:0]        err_cnt_r;

  logic              bit_s;
  logic [WIDTH-1:0]  resolved_s;
  logic [1:0]        flags_s;
  logic              last_s;
  logic              handshake_s;

  // Returns {step_err, step_dir}; modular difference makes wrap-around a legal step.
  function automatic logic [1:0] step_flags(input logic [WIDTH-1:0] cur,
                                            input logic [WIDTH-1:0] prev,
                                            input logic             valid);
    logic [WIDTH-1:0] diff;
    diff = cur - prev;
    if (!valid) begin
      step_flags = 2'b00;
    end else if (diff == {{(WIDTH-1){1'b0}}, 1'b1}) begin
      step_flags = 2'b01;
    end else if (diff == {WIDTH{1'b1}}) begin
      step_flags = 2'b00;
    end else begin
      step_flags = 2'b10;
    end
  endfunction

  // Current-bit resolution, handshake decode and step evaluation.
  always_comb begin
    bit_s       = shift_r[0] ^ gray_r[idx_r];
    resolved_s  = {shift_r[WIDTH-2:0], bit_s};
    last_s      = (idx_r == {IDXW{1'b0}});
    handshake_s = (state_r == DONE) && out_ready;
    flags_s     = step_flags(resolved_s, hist_r, hist_valid_r);
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) state_s = CONV;
        else          state_s = IDLE;
      end
      CONV: begin
        if (last_s) state_s = DONE;
        else        state_s = CONV;
      end
      DONE: begin
        if (out_ready) state_s = IDLE;
        else           state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_s;
  end

  // Conversion datapath and registered handshake/result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      gray_r      <= {WIDTH{1'b0}};
      shift_r     <= {WIDTH{1'b0}};
      bin_r       <= {WIDTH{1'b0}};
      idx_r       <= {IDXW{1'b0}};
      step_err_r  <= 1'b0;
      step_dir_r  <= 1'b0;
    end else begin
      in_ready_r  <= (state_s == IDLE);
      out_valid_r <= (state_s == DONE);
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            gray_r  <= gray_in;
            shift_r <= {WIDTH{1'b0}};
            idx_r   <= IDXW'(WIDTH - 1);
          end
        end
        CONV: begin
          // shift_r[0] carries bin[i+1]; it is zero for the MSB.
          shift_r <= resolved_s;
          if (last_s) begin
            bin_r      <= resolved_s;
            step_err_r <= flags_s[1];
            step_dir_r <= flags_s[0];
          end else begin
            idx_r <= idx_r - IDXW'(1);
          end
        end
        DONE: begin
          shift_r <= shift_r;
        end
        default: begin
          shift_r <= {WIDTH{1'b0}};
        end
      endcase
    end
  end

  // History and error counter; a history clear overrides a coincident handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_r       <= {WIDTH{1'b0}};
      hist_valid_r <= 1'b0;
      err_cnt_r    <= 8'd0;
    end else begin
      if (handshake_s) begin
        hist_r <= bin_r;
        if (step_err_r && (err_cnt_r != 8'hFF)) err_cnt_r <= err_cnt_r + 8'd1;
      end
      if (hist_clr)         hist_valid_r <= 1'b0;
      else if (handshake_s) hist_valid_r <= 1'b1;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign bin_out   = bin_r;
  assign step_err  = step_err_r;
  assign step_dir  = step_dir_r;
  assign err_cnt   = err_cnt_r;

endmodule
